// File: rtl/mac_r4_iter.sv
// Iterative multiply-accumulate: radix-4 Booth multiplier (two multiplier bits per cycle)
// feeding a guarded accumulator with sticky overflow, behind a valid/ready operand handshake.
module mac_r4_iter #(
   parameter int W         = 256,
   parameter int ACC_GUARD = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             a,
   input  logic [W-1:0]             b,
   input  logic                     is_signed,
   input  logic                     acc_clear,
   output logic                     out_valid,
   output logic [2*W+ACC_GUARD-1:0] acc,
   output logic                     busy,
   output logic                     ovf
);
   localparam int ACC_W = 2*W + ACC_GUARD;
   localparam int P_W   = 2*W;
   localparam int CNT_W = $clog2(W/2 + 2);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W/2 + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic [P_W-1:0]     a_sh_q, a_sh_d;
   logic [W+2:0]       b_sh_q, b_sh_d;
   logic [P_W-1:0]     pp_q, pp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sgn_q, sgn_d;
   logic               clr_q, clr_d;

   logic [ACC_W-1:0]   base_s;
   logic [ACC_W-1:0]   prod_ext_s;
   logic [ACC_W:0]     sum_s;
   logic               op_ovf_s;

   // Product is only needed modulo 2^(2W), so the multiple is formed at that width.
   function automatic logic [P_W-1:0] booth_addend(input logic [2:0] trip,
                                                   input logic [P_W-1:0] m);
      logic [P_W-1:0] r;
      case (trip)
         3'b001, 3'b010: r = m;
         3'b011:         r = {m[P_W-2:0], 1'b0};
         3'b100:         r = -{m[P_W-2:0], 1'b0};
         3'b101, 3'b110: r = -m;
         default:        r = '0;
      endcase
      return r;
   endfunction

   // Next-state, datapath and output decode
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      pp_d        = pp_q;
      cnt_d       = cnt_q;
      sgn_d       = sgn_q;
      clr_d       = clr_q;

      base_s      = clr_q ? '0 : acc_q;
      if (sgn_q) begin
         prod_ext_s = ACC_W'(signed'(pp_q));
      end else begin
         prod_ext_s = ACC_W'(pp_q);
      end
      sum_s = {1'b0, base_s} + {1'b0, prod_ext_s};
      if (sgn_q) begin
         op_ovf_s = (base_s[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                    (sum_s[ACC_W-1] != base_s[ACC_W-1]);
      end else begin
         op_ovf_s = sum_s[ACC_W];
      end

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               // Extension to W+2 bits lets one extra digit absorb the unsigned top bits.
               a_sh_d  = is_signed ? P_W'(signed'(a)) : P_W'(a);
               b_sh_d  = {{2{b[W-1] & is_signed}}, b, 1'b0};
               sgn_d   = is_signed;
               clr_d   = acc_clear;
               pp_d    = '0;
               cnt_d   = CNT_INIT;
               state_d = ST_MUL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            pp_d   = pp_q + booth_addend(b_sh_q[2:0], a_sh_q);
            a_sh_d = {a_sh_q[P_W-3:0], 2'b00};
            b_sh_d = {2'b00, b_sh_q[W+2:2]};
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_ACC;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_ACC: begin
            acc_d   = sum_s[ACC_W-1:0];
            ovf_d   = clr_q ? op_ovf_s : (ovf_q | op_ovf_s);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      out_valid_d = (state_q == ST_ACC);
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         pp_q        <= '0;
         cnt_q       <= '0;
         sgn_q       <= 1'b0;
         clr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         pp_q        <= pp_d;
         cnt_q       <= cnt_d;
         sgn_q       <= sgn_d;
         clr_q       <= clr_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign acc       = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_r4_iter.sv
// Scoreboard bench for mac_r4_iter: W=8 with 8 and 0 guard bits (directed vectors)
// and the default W=256 against a reference model.
module tb_mac_r4_iter;
   typedef struct {
      logic [519:0] acc;
      logic         ovf;
      int           cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    iv = 3'b000;
   logic [255:0]  a_s = '0;
   logic [255:0]  b_s = '0;
   logic          sgn_s = 1'b0;
   logic          clr_s = 1'b0;

   logic          rdy8, rdyg, rdy256;
   logic          ov8, ovg, ov256;
   logic          bsy8, bsyg, bsy256;
   logic          ovf8, ovfg, ovf256;
   logic [23:0]   acc8;
   logic [15:0]   accg;
   logic [519:0]  acc256;
   logic [2:0]    rdys, ovs, prev_ov;

   exp_t          q0[$];
   exp_t          q1[$];
   exp_t          q2[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            lat[3] = '{6, 6, 130};
   logic [519:0]  m_acc;
   logic          m_ovf;

   assign rdys = {rdy256, rdyg, rdy8};
   assign ovs  = {ov256, ovg, ov8};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_r4_iter #(.W(8), .ACC_GUARD(8)) u_g8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy8),
      .a(a_s[7:0]), .b(b_s[7:0]), .is_signed(sgn_s), .acc_clear(clr_s),
      .out_valid(ov8), .acc(acc8), .busy(bsy8), .ovf(ovf8));

   mac_r4_iter #(.W(8), .ACC_GUARD(0)) u_g0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdyg),
      .a(a_s[7:0]), .b(b_s[7:0]), .is_signed(sgn_s), .acc_clear(clr_s),
      .out_valid(ovg), .acc(accg), .busy(bsyg), .ovf(ovfg));

   mac_r4_iter u_w256 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy256),
      .a(a_s), .b(b_s), .is_signed(sgn_s), .acc_clear(clr_s),
      .out_valid(ov256), .acc(acc256), .busy(bsy256), .ovf(ovf256));

   task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor side: pop and compare whenever an instance strobes out_valid
   task automatic mon(input int k, input logic [519:0] av, input logic of, input logic v);
      exp_t e;
      logic empty;
      if (v) begin
         chk($sformatf("dut%0d_single_cycle_valid", k), prev_ov[k], 1'b0);
         empty = 1'b0;
         case (k)
            0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
            1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
            default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
         endcase
         if (empty) begin
            fail_now($sformatf("dut%0d_unexpected_out_valid", k));
         end else begin
            chk($sformatf("dut%0d_acc", k), av, e.acc);
            chk($sformatf("dut%0d_ovf", k), of, e.ovf);
            chk($sformatf("dut%0d_latency", k), cyc - e.cyc, lat[k]);
         end
      end
      prev_ov[k] = v;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, {496'd0, acc8}, ovf8, ov8);
         mon(1, {504'd0, accg}, ovfg, ovg);
         mon(2, acc256, ovf256, ov256);
      end
   end

   // Offer one operand pair to instance k; push the expectation at the accepting edge
   task automatic send(input int k, input logic [255:0] av, input logic [255:0] bv,
                       input logic s, input logic c, input logic push, input logic b2b,
                       input logic [519:0] e_acc, input logic e_ovf);
      exp_t e;
      logic got;
      got = 1'b0;
      @(negedge clk);
      a_s = av; b_s = bv; sgn_s = s; clr_s = c;
      iv[k] = 1'b1;
      for (int n = 0; n < 400 && !got; n++) begin
         if (rdys[k]) begin
            if (b2b) chk($sformatf("dut%0d_accept_with_out_valid", k), ovs[k], 1'b1);
            @(posedge clk);
            #1;
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      iv[k] = 1'b0;
      if (!got) begin
         fail_now($sformatf("dut%0d_accept_timeout", k));
      end else if (push) begin
         e.acc = e_acc; e.ovf = e_ovf; e.cyc = cyc;
         case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if ((q0.size() + q1.size() + q2.size()) != 0) fail_now("drain_timeout");
   endtask

   function automatic logic [255:0] pick();
      logic [255:0] r;
      case ($urandom_range(0, 5))
         0: r = '0;
         1: r = '1;
         2: r = {1'b1, 255'd0};
         3: r = {1'b0, {255{1'b1}}};
         default: for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom();
      endcase
      return r;
   endfunction

   task automatic model(input logic [255:0] av, input logic [255:0] bv,
                        input logic s, input logic c);
      logic signed [519:0] sa, sb;
      logic [519:0] p, base;
      logic [520:0] sum;
      logic op_ovf;
      sa = $signed(av);
      sb = $signed(bv);
      if (s) p = sa * sb;
      else   p = {264'd0, av} * {264'd0, bv};
      base = c ? 520'd0 : m_acc;
      sum = {1'b0, base} + {1'b0, p};
      if (s) op_ovf = (base[519] == p[519]) && (sum[519] != base[519]);
      else   op_ovf = sum[520];
      m_ovf = c ? op_ovf : (m_ovf | op_ovf);
      m_acc = sum[519:0];
   endtask

   initial begin
      prev_ov = 3'b000;
      repeat (3) @(negedge clk);
      chk("reset_acc", {496'd0, acc8}, 520'd0);
      chk("reset_ovf", ovf8, 1'b0);
      chk("reset_in_ready", rdy8, 1'b0);
      chk("reset_busy", bsy8, 1'b0);
      chk("reset_out_valid", ov8, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_in_ready", rdys, 3'b111);

      // W=8, 8 guard bits
      send(0, 256'hFF, 256'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 520'd65025, 1'b0);
      send(0, 256'h80, 256'h80, 1'b1, 1'b1, 1'b1, 1'b0, 520'd16384, 1'b0);
      send(0, 256'h80, 256'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 520'd128, 1'b0);
      send(0, 256'h03, 256'h05, 1'b1, 1'b1, 1'b1, 1'b0, 520'd15, 1'b0);
      send(0, 256'h07, 256'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 520'd1, 1'b0);

      // W=8, no guard bits: unsigned carry, clear, signed overflow and stickiness
      send(1, 256'hFF, 256'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 520'd65025, 1'b0);
      send(1, 256'hFF, 256'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 520'd64514, 1'b1);
      send(1, 256'h01, 256'h01, 1'b0, 1'b1, 1'b1, 1'b0, 520'd1, 1'b0);
      send(1, 256'h80, 256'h80, 1'b1, 1'b1, 1'b1, 1'b0, 520'd16384, 1'b0);
      send(1, 256'h80, 256'h80, 1'b1, 1'b0, 1'b1, 1'b0, 520'd32768, 1'b1);
      send(1, 256'h80, 256'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 520'd16512, 1'b1);

      // Back-to-back: each follower must be taken while its predecessor strobes
      send(0, 256'd10,  256'd20,  1'b0, 1'b1, 1'b1, 1'b0, 520'd200, 1'b0);
      send(0, 256'd3,   256'd4,   1'b0, 1'b0, 1'b1, 1'b1, 520'd212, 1'b0);
      send(0, 256'd255, 256'd1,   1'b0, 1'b0, 1'b1, 1'b1, 520'd467, 1'b0);
      send(0, 256'd100, 256'd100, 1'b0, 1'b0, 1'b1, 1'b1, 520'd10467, 1'b0);
      drain(1000);

      // Reset three cycles into MUL: no result, everything cleared
      send(0, 256'd9, 256'd9, 1'b0, 1'b0, 1'b0, 1'b0, 520'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midop_reset_acc", {496'd0, acc8}, 520'd0);
      chk("midop_reset_ovf_g0", ovfg, 1'b0);
      chk("midop_reset_acc_g0", {504'd0, accg}, 520'd0);
      chk("midop_reset_busy", bsy8, 1'b0);
      chk("midop_reset_in_ready", rdy8, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midop_release_in_ready", rdy8, 1'b1);
      repeat (10) @(negedge clk);
      send(0, 256'd6, 256'd7, 1'b0, 1'b0, 1'b1, 1'b0, 520'd42, 1'b0);

      // Default W=256 against the reference model
      m_acc = '0;
      m_ovf = 1'b0;
      for (int i = 0; i < 200; i++) begin
         logic [255:0] av, bv;
         logic s, c;
         av = pick();
         bv = pick();
         s  = 1'($urandom_range(0, 1));
         c  = (i == 0) || ($urandom_range(0, 7) == 0);
         model(av, bv, s, c);
         send(2, av, bv, s, c, 1'b1, 1'b0, m_acc, m_ovf);
      end
      drain(1000);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
